shifter_pipe: RTL and testbench



---
 rtl/shifter_pipe.sv | 139 +++++++++++++
 tb/tb_shifter_pipe.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one shift level per stage, MSB level first, with a
// valid/ready elastic handshake. Supports logical/arithmetic shifts and rotates.
module shifter_pipe #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     In_Valid,
    output logic                     In_Ready,
    input  logic [WIDTH-1:0]         X,
    input  logic [$clog2(WIDTH)-1:0] Sa,
    input  logic                     Right,
    input  logic                     Arith,
    input  logic                     Rotate,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic [WIDTH-1:0]         Sh,
    output logic                     Zero
);

    localparam int unsigned SAW  = $clog2(WIDTH);
    localparam int unsigned NMID = SAW - 1;

    // Per-beat control carried alongside the data; sa is kept MSB-aligned so
    // each stage always consumes bit SAW-1.
    typedef struct packed {
        logic [SAW-1:0] sa;
        logic           right;
        logic           arith;
        logic           rot;
        logic           msb;
    } ctl_t;

    function automatic logic [WIDTH-1:0] shift_level(
        input logic [WIDTH-1:0] d,
        input int unsigned      s,
        input logic             en,
        input logic             right,
        input logic             arith,
        input logic             rot,
        input logic             msb
    );
        logic [WIDTH-1:0] fill;
        logic [WIDTH-1:0] res;
        fill = (arith && msb) ? ~({WIDTH{1'b1}} >> s) : '0;
        if (!en) begin
            res = d;
        end else if (rot) begin
            res = right ? ((d >> s) | (d << (WIDTH - s)))
                        : ((d << s) | (d >> (WIDTH - s)));
        end else if (right) begin
            res = (d >> s) | fill;
        end else begin
            res = d << s;
        end
        return res;
    endfunction

    ctl_t             in_ctl;
    logic [WIDTH-1:0] data_q [SAW];
    logic [WIDTH-1:0] data_d [SAW];
    logic [SAW-1:0]   valid_q;
    logic [SAW-1:0]   valid_d;
    ctl_t             ctl_q [NMID];
    ctl_t             ctl_d [NMID];
    logic             zero_q;
    logic             zero_d;
    logic [SAW-1:0]   stage_ready;
    logic             unused_sa_tail;

    // Next-state: ready chain, stage advance and the registered zero flag.
    always_comb begin : p_next
        in_ctl  = '{sa: Sa, right: Right, arith: Arith, rot: Rotate, msb: X[WIDTH-1]};
        valid_d = valid_q;
        data_d  = data_q;
        ctl_d   = ctl_q;
        zero_d  = zero_q;

        // Stage k can move unless it and every stage below it are full and stalled.
        for (int k = 0; k < SAW; k++) begin
            stage_ready[k] = Out_Ready || !(&(valid_q | SAW'((1 << k) - 1)));
        end

        if (stage_ready[0]) begin
            valid_d[0] = In_Valid;
            if (In_Valid) begin
                data_d[0] = shift_level(X, WIDTH / 2, in_ctl.sa[SAW-1], in_ctl.right,
                                        in_ctl.arith, in_ctl.rot, in_ctl.msb);
                ctl_d[0]    = in_ctl;
                ctl_d[0].sa = SAW'(in_ctl.sa << 1);
            end
        end

        for (int k = 1; k < SAW; k++) begin
            if (stage_ready[k]) begin
                valid_d[k] = valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_d[k] = shift_level(data_q[k-1], WIDTH >> (k + 1),
                                            ctl_q[k-1].sa[SAW-1], ctl_q[k-1].right,
                                            ctl_q[k-1].arith, ctl_q[k-1].rot,
                                            ctl_q[k-1].msb);
                end
            end
        end

        for (int k = 1; k < NMID; k++) begin
            if (stage_ready[k] && valid_q[k-1]) begin
                ctl_d[k]    = ctl_q[k-1];
                ctl_d[k].sa = SAW'(ctl_q[k-1].sa << 1);
            end
        end

        if (stage_ready[SAW-1] && valid_q[SAW-2]) begin
            zero_d = (data_d[SAW-1] == '0);
        end
    end

    always_ff @(posedge Clk) begin : p_regs
        if (Reset) begin
            valid_q <= '0;
            data_q  <= '{default: '0};
            ctl_q   <= '{default: '0};
            zero_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            ctl_q   <= ctl_d;
            zero_q  <= zero_d;
        end
    end

    assign In_Ready       = stage_ready[0] & ~Reset;
    assign Out_Valid      = valid_q[SAW-1];
    assign Sh             = data_q[SAW-1];
    assign Zero           = zero_q;
    // Shifted-in padding of the last stored shift amount is never consumed.
    assign unused_sa_tail = ^ctl_q[NMID-1].sa[SAW-2:0];

endmodule

// File: tb/tb_shifter_pipe.sv
// Directed bench for shifter_pipe: WIDTH=32 and WIDTH=8 instances sharing the
// clock and reset; inputs driven and outputs sampled around the falling edge.
module tb_shifter_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid, in_ready, right, arith, rot, out_valid, out_ready, zero;
    logic [31:0] x, sh;
    logic [4:0]  sa;

    logic        in_valid8, in_ready8, right8, arith8, rot8, out_valid8, out_ready8, zero8;
    logic [7:0]  x8, sh8;
    logic [2:0]  sa8;

    int n_checks = 0;
    int n_pass   = 0;

    shifter_pipe #(.WIDTH(32)) u_dut (
        .Clk(clk), .Reset(rst), .In_Valid(in_valid), .In_Ready(in_ready),
        .X(x), .Sa(sa), .Right(right), .Arith(arith), .Rotate(rot),
        .Out_Valid(out_valid), .Out_Ready(out_ready), .Sh(sh), .Zero(zero)
    );

    shifter_pipe #(.WIDTH(8)) u_dut8 (
        .Clk(clk), .Reset(rst), .In_Valid(in_valid8), .In_Ready(in_ready8),
        .X(x8), .Sa(sa8), .Right(right8), .Arith(arith8), .Rotate(rot8),
        .Out_Valid(out_valid8), .Out_Ready(out_ready8), .Sh(sh8), .Zero(zero8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Bit-level reference, used for the random backpressure stream.
    function automatic logic [31:0] ref_shift(input logic [31:0] xv, input int s,
                                              input logic r, input logic a, input logic ro);
        logic [31:0] res;
        for (int i = 0; i < 32; i++) begin
            if (ro)      res[i] = r ? xv[(i + s) % 32] : xv[(i + 32 - s) % 32];
            else if (r)  res[i] = (i + s < 32) ? xv[i + s] : (a & xv[31]);
            else         res[i] = (i >= s) ? xv[i - s] : 1'b0;
        end
        return res;
    endfunction

    task automatic send_single(input string tag, input logic [31:0] xv, input logic [4:0] sv,
                               input logic r, input logic a, input logic ro,
                               input logic [31:0] exp);
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        x = xv; sa = sv; right = r; arith = a; rot = ro; in_valid = 1'b1;
        #1 check({tag, " in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd5);
        check({tag, " sh"}, sh, exp);
        check({tag, " zero"}, 32'(zero), 32'(exp == 32'd0));
    endtask

    task automatic send8(input string tag, input logic [7:0] xv, input logic [2:0] sv,
                         input logic r, input logic a, input logic ro, input logic [7:0] exp);
        int lat;
        @(negedge clk);
        x8 = xv; sa8 = sv; right8 = r; arith8 = a; rot8 = ro; in_valid8 = 1'b1;
        @(negedge clk);
        in_valid8 = 1'b0;
        lat = 1;
        while (!out_valid8 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
        check({tag, " sh"}, 32'(sh8), 32'(exp));
    endtask

    logic [31:0] bx [12];
    logic [4:0]  bsa [12];
    logic        br [12], ba [12], bro [12];
    logic [31:0] exp_q [$];
    logic [31:0] stall_ref;
    int          sent, emitted, stale, stall_bad;
    bit          stall_seen, saw_full;

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        x = '0; sa = '0; right = 1'b0; arith = 1'b0; rot = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1;
        x8 = '0; sa8 = '0; right8 = 1'b0; arith8 = 1'b0; rot8 = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #1 check("rst in_ready low", 32'(in_ready), 32'd0);
        check("rst in_ready8 low", 32'(in_ready8), 32'd0);
        rst = 1'b0;
        #1 check("post-rst in_ready", 32'(in_ready), 32'd1);
        check("post-rst out_valid", 32'(out_valid), 32'd0);
        check("post-rst sh", sh, 32'd0);
        check("post-rst zero", 32'(zero), 32'd0);

        // Single beats: shifts, then rotates
        send_single("sll31", 32'h0000_0001, 5'd31, 1'b0, 1'b0, 1'b0, 32'h8000_0000);
        send_single("srl4",  32'h8000_0000, 5'd4,  1'b1, 1'b0, 1'b0, 32'h0800_0000);
        send_single("sra4",  32'h8000_0000, 5'd4,  1'b1, 1'b1, 1'b0, 32'hF800_0000);
        send_single("ror8",  32'h1234_5678, 5'd8,  1'b1, 1'b0, 1'b1, 32'h7812_3456);
        send_single("rol1",  32'h8000_0001, 5'd1,  1'b0, 1'b0, 1'b1, 32'h0000_0003);
        send_single("ror_arith", 32'h8000_0000, 5'd4, 1'b1, 1'b1, 1'b1, 32'h0800_0000);

        // Reset with three beats in flight; Sh currently holds 0x08000000
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            x = 32'h0000_00F0 + 32'(i); sa = 5'd1; right = 1'b0; arith = 1'b0; rot = 1'b0;
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        #1 check("midrst in_ready low", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1 check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst sh", sh, 32'd0);
        check("midrst zero", 32'(zero), 32'd0);
        check("midrst in_ready back", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("midrst stale beats", 32'(stale), 32'd0);
        send_single("after_rst", 32'h0000_0003, 5'd2, 1'b0, 1'b0, 1'b0, 32'h0000_000C);

        // Sa=0 is identity in every mode
        send_single("sa0 sll", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF);
        send_single("sa0 srl", 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        send_single("sa0 sra", 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF);
        send_single("sa0 rol", 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        send_single("sa0 ror", 32'hDEAD_BEEF, 5'd0, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Back-to-back beats, Zero only on the second
        @(negedge clk);
        x = 32'hFFFF_FFFF; sa = 5'd31; right = 1'b0; arith = 1'b0; rot = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        x = 32'h0000_0001; sa = 5'd1; right = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
        check("b2b first sh", sh, 32'h8000_0000);
        check("b2b first zero", 32'(zero), 32'd0);
        @(negedge clk);
        check("b2b second valid", 32'(out_valid), 32'd1);
        check("b2b second sh", sh, 32'd0);
        check("b2b second zero", 32'(zero), 32'd1);

        // Backpressure: 12 random beats, consumer stalled in cycles 3..12
        for (int i = 0; i < 12; i++) begin
            bx[i] = $urandom; bsa[i] = 5'($urandom_range(0, 31));
            br[i] = 1'($urandom); ba[i] = 1'($urandom); bro[i] = 1'($urandom);
        end
        sent = 0; emitted = 0; stall_bad = 0; stall_seen = 0; saw_full = 0;
        stall_ref = '0;
        exp_q.delete();
        @(negedge clk);
        for (int cyc = 0; cyc < 80 && emitted < 12; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 12);
            if (sent < 12) begin
                x = bx[sent]; sa = bsa[sent]; right = br[sent]; arith = ba[sent]; rot = bro[sent];
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                check($sformatf("bp beat %0d", emitted), sh,
                      (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX);
                emitted++;
            end
            if (out_valid && !out_ready) begin
                if (!stall_seen) begin
                    stall_seen = 1;
                    stall_ref  = sh;
                end else if (sh !== stall_ref) begin
                    stall_bad++;
                end
            end
            if (in_valid && !in_ready && !saw_full) begin
                saw_full = 1;
                check("bp occupancy at in_ready drop", 32'(sent - emitted), 32'd5);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_shift(bx[sent], int'(bsa[sent]), br[sent], ba[sent], bro[sent]));
                sent++;
            end
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp emitted count", 32'(emitted), 32'd12);
        check("bp in_ready dropped", 32'(saw_full), 32'd1);
        check("bp stall sh stable", 32'(stall_bad), 32'd0);
        stale = 0;
        repeat (8) begin
            #1 if (out_valid) stale++;
            @(negedge clk);
        end
        check("bp no duplicates", 32'(stale), 32'd0);

        // WIDTH=8 instance
        send8("w8 sra3", 8'h90, 3'd3, 1'b1, 1'b1, 1'b0, 8'hF2);
        send8("w8 ror1", 8'h81, 3'd1, 1'b1, 1'b0, 1'b1, 8'hC0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
